// File: rtl/axi4_bram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_bram_slave
// Purpose  : AXI4 INCR-burst slave in front of a synchronous-read block RAM.
// Revision : 1.0
// ============================================================================
module axi4_bram_slave #(
   parameter int A_WIDTH  = 26,
   parameter int D_WIDTH  = 16,
   parameter int M_AWIDTH = 10
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               awvalid,
   output logic               awready,
   input  logic [A_WIDTH-1:0] awaddr,
   input  logic [7:0]         awlen,
   input  logic               wvalid,
   output logic               wready,
   input  logic               wlast,
   input  logic [D_WIDTH-1:0] wdata,
   output logic               bvalid,
   input  logic               bready,
   output logic [1:0]         bresp,
   input  logic               arvalid,
   output logic               arready,
   input  logic [A_WIDTH-1:0] araddr,
   input  logic [7:0]         arlen,
   output logic               rvalid,
   input  logic               rready,
   output logic               rlast,
   output logic [D_WIDTH-1:0] rdata,
   output logic [1:0]         rresp
);

   localparam int OFF_BITS = $clog2(D_WIDTH / 8);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_DATA  = 3'd1,
      W_RESP  = 3'd2,
      R_FETCH = 3'd3,
      R_DATA  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [M_AWIDTH-1:0] idx_q, idx_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mis_q, mis_d;
   logic [D_WIDTH-1:0]  rdata_q;

   logic                mem_we;
   logic                rd_en;
   logic [M_AWIDTH-1:0] rd_addr;
   logic                last_beat;
   logic [M_AWIDTH-1:0] idx_nxt;
   logic [M_AWIDTH-1:0] aw_idx;
   logic [M_AWIDTH-1:0] ar_idx;
   logic                unused_addr_bits;

   logic [D_WIDTH-1:0]  mem [0:(1<<M_AWIDTH)-1];

   // Byte-offset bits and address bits above the memory depth are dropped.
   assign aw_idx           = awaddr[OFF_BITS +: M_AWIDTH];
   assign ar_idx           = araddr[OFF_BITS +: M_AWIDTH];
   assign unused_addr_bits = ^{awaddr, araddr};

   assign last_beat = (cnt_q == len_q);
   assign idx_nxt   = idx_q + M_AWIDTH'(1);
   assign rdata     = rdata_q;
   assign rresp     = 2'b00;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      mis_d   = mis_q;
      awready = 1'b0;
      arready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = 2'b00;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      mem_we  = 1'b0;
      rd_en   = 1'b0;
      rd_addr = idx_q;
      case (state_q)
         IDLE: begin
            awready = 1'b1;
            arready = ~awvalid;
            if (awvalid) begin
               idx_d   = aw_idx;
               len_d   = awlen;
               cnt_d   = 8'd0;
               mis_d   = 1'b0;
               state_d = W_DATA;
            end else if (arvalid) begin
               idx_d   = ar_idx;
               len_d   = arlen;
               cnt_d   = 8'd0;
               state_d = R_FETCH;
            end
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               mem_we = 1'b1;
               // Burst length comes from awlen; wlast is only cross-checked.
               if (wlast != last_beat) mis_d = 1'b1;
               if (last_beat) begin
                  state_d = W_RESP;
               end else begin
                  cnt_d = cnt_q + 8'd1;
                  idx_d = idx_nxt;
               end
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            bresp  = mis_q ? 2'b10 : 2'b00;
            if (bready) state_d = IDLE;
         end
         R_FETCH: begin
            rd_en   = 1'b1;
            state_d = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            rlast  = last_beat;
            rd_en  = 1'b1;
            // Re-reading the current word while stalled keeps rdata stable.
            if (rready) begin
               rd_addr = idx_nxt;
               if (last_beat) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 8'd1;
                  idx_d = idx_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= 8'd0;
         cnt_q   <= 8'd0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         mis_q   <= mis_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (mem_we) mem[idx_q] <= wdata;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= mem[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_bram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_bram_slave
// Purpose  : Cycle-by-cycle vector bench for axi4_bram_slave.
// Revision : 1.0
// ============================================================================
module tb_axi4_bram_slave;

   logic        aclk = 1'b0;
   logic        aresetn, awvalid, wvalid, wlast, bready, arvalid, rready;
   logic [25:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [15:0] wdata, rdata;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [1:0]  bresp, rresp;

   axi4_bram_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata), .rresp(rresp)
   );

   always #5 aclk = ~aclk;

   // Expected flags: {awready, arready, wready, bvalid, bresp[1:0], rvalid, rlast}
   localparam logic [7:0] EX_IDLE = 8'b1100_0000;
   localparam logic [7:0] EX_AWV  = 8'b1000_0000;
   localparam logic [7:0] EX_W    = 8'b0010_0000;
   localparam logic [7:0] EX_B    = 8'b0001_0000;
   localparam logic [7:0] EX_BERR = 8'b0001_1000;
   localparam logic [7:0] EX_NONE = 8'b0000_0000;
   localparam logic [7:0] EX_R    = 8'b0000_0010;
   localparam logic [7:0] EX_RL   = 8'b0000_0011;

   typedef struct {
      logic        rstn;
      logic        awv;
      logic [25:0] awa;
      logic [7:0]  awl;
      logic        wv;
      logic        wl;
      logic [15:0] wd;
      logic        br;
      logic        arv;
      logic [25:0] ara;
      logic [7:0]  arl;
      logic        rr;
      logic [7:0]  ex;
      logic        chk_rd;
      logic [15:0] exd;
   } vec_t;

   int    n_chk  = 0;
   int    n_pass = 0;
   logic  rl_hs;
   vec_t  tbl[$];
   string tags[$];

   function automatic vec_t nop(input logic [7:0] ex);
      vec_t v;
      v = '{default: '0};
      v.rstn = 1'b1;
      v.ex   = ex;
      return v;
   endfunction

   function automatic vec_t c_aw(input logic [25:0] a, input logic [7:0] l, input logic [7:0] ex);
      vec_t v;
      v = nop(ex);
      v.awv = 1'b1; v.awa = a; v.awl = l;
      return v;
   endfunction

   function automatic vec_t c_ar(input logic [25:0] a, input logic [7:0] l, input logic [7:0] ex);
      vec_t v;
      v = nop(ex);
      v.arv = 1'b1; v.ara = a; v.arl = l;
      return v;
   endfunction

   function automatic vec_t c_w(input logic [15:0] d, input logic last, input logic [7:0] ex = EX_W);
      vec_t v;
      v = nop(ex);
      v.wv = 1'b1; v.wd = d; v.wl = last;
      return v;
   endfunction

   function automatic vec_t c_b(input logic [7:0] ex);
      vec_t v;
      v = nop(ex);
      v.br = 1'b1;
      return v;
   endfunction

   function automatic vec_t c_r(input logic rr, input logic [7:0] ex, input logic [15:0] d);
      vec_t v;
      v = nop(ex);
      v.rr = rr; v.chk_rd = 1'b1; v.exd = d;
      return v;
   endfunction

   task automatic add(input vec_t v, input string t);
      tbl.push_back(v);
      tags.push_back(t);
   endtask

   // Apply one cycle of inputs, compare the outputs they produce, then clock.
   task automatic run(input vec_t v, input string t);
      logic [7:0] act;
      aresetn = v.rstn;
      awvalid = v.awv; awaddr = v.awa; awlen = v.awl;
      wvalid  = v.wv;  wlast  = v.wl;  wdata = v.wd;
      bready  = v.br;
      arvalid = v.arv; araddr = v.ara; arlen = v.arl;
      rready  = v.rr;
      #2;
      act   = {awready, arready, wready, bvalid, bresp, rvalid, rlast};
      rl_hs = rvalid & rready & rlast;
      n_chk++;
      if (act !== v.ex || rresp !== 2'b00 || (v.chk_rd && rdata !== v.exd))
         $display("FAIL %s: flags=%b rresp=%b rdata=%h, required flags=%b rresp=00 rdata=%h (checked=%0d)",
                  t, act, rresp, rdata, v.ex, v.exd, v.chk_rd);
      else
         n_pass++;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   beat;
      int   rl_cnt;
      logic done;

      aresetn = 1'b0; awvalid = 1'b0; awaddr = '0; awlen = '0;
      wvalid = 1'b0; wlast = 1'b0; wdata = '0; bready = 1'b0;
      arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;

      // Reset state and arready following awvalid
      v = nop(EX_IDLE); v.rstn = 1'b0; v.chk_rd = 1'b1; v.exd = 16'h0; add(v, "reset");
      v = nop(EX_AWV);  v.rstn = 1'b0; v.awv = 1'b1;                    add(v, "reset_arready");
      v = nop(EX_IDLE); v.chk_rd = 1'b1; v.exd = 16'h0;                 add(v, "post_reset");
      // 4-beat write then read back at the same address
      add(c_aw(26'h10, 8'd3, EX_AWV), "aw_burst4");
      add(c_w(16'h1111, 1'b0), "w_beat1");
      add(c_w(16'h2222, 1'b0), "w_beat2");
      add(c_w(16'h3333, 1'b0), "w_beat3");
      add(c_w(16'h4444, 1'b1), "w_beat4");
      add(nop(EX_B),  "b_hold");
      add(c_b(EX_B),  "b_ok");
      add(c_ar(26'h10, 8'd3, EX_IDLE), "ar_burst4");
      add(nop(EX_NONE), "r_fetch");
      add(c_r(1'b1, EX_R,  16'h1111), "r_beat1");
      add(c_r(1'b1, EX_R,  16'h2222), "r_beat2");
      add(c_r(1'b1, EX_R,  16'h3333), "r_beat3");
      add(c_r(1'b1, EX_RL, 16'h4444), "r_beat4");
      // Single-beat write latency and one-cycle turnaround
      add(c_aw(26'h40, 8'd0, EX_AWV), "aw_single");
      add(c_w(16'h5A5A, 1'b1), "w_single");
      add(c_b(EX_B), "b_single");
      add(c_ar(26'h40, 8'd0, EX_IDLE), "ar_turnaround");
      add(nop(EX_NONE), "r_fetch_single");
      add(c_r(1'b1, EX_RL, 16'h5A5A), "r_single");
      // wlast on the wrong beat: both writes land, SLVERR response
      add(c_aw(26'h80, 8'd1, EX_AWV), "aw_mismatch");
      add(c_w(16'hC0DE, 1'b1), "w_early_last");
      add(c_w(16'hBEEF, 1'b0), "w_missing_last");
      add(c_b(EX_BERR), "b_mismatch");
      add(c_ar(26'h80, 8'd1, EX_IDLE), "ar_mismatch");
      add(nop(EX_NONE), "r_fetch_mismatch");
      add(c_r(1'b1, EX_R,  16'hC0DE), "r_mismatch1");
      add(c_r(1'b1, EX_RL, 16'hBEEF), "r_mismatch2");
      // Address wrap from the last word to word 0, with a wvalid gap
      add(c_aw(26'h7FE, 8'd1, EX_AWV), "aw_wrap");
      add(c_w(16'hAAAA, 1'b0), "w_wrap1");
      add(nop(EX_W), "w_gap");
      add(c_w(16'hBBBB, 1'b1), "w_wrap2");
      add(c_b(EX_B), "b_wrap");
      add(c_ar(26'h7FE, 8'd1, EX_IDLE), "ar_wrap");
      add(nop(EX_NONE), "r_fetch_wrap");
      add(c_r(1'b1, EX_R,  16'hAAAA), "r_wrap_3ff");
      add(c_r(1'b1, EX_RL, 16'hBBBB), "r_wrap_0");
      add(c_ar(26'h0, 8'd0, EX_IDLE), "ar_word0");
      add(nop(EX_NONE), "r_fetch_word0");
      add(c_r(1'b1, EX_RL, 16'hBBBB), "r_word0");
      add(c_ar(26'h7FF, 8'd0, EX_IDLE), "ar_byte_offset");
      add(nop(EX_NONE), "r_fetch_offset");
      add(c_r(1'b1, EX_RL, 16'hAAAA), "r_byte_offset");
      add(nop(EX_IDLE), "idle_end");

      for (int i = 0; i < tbl.size(); i++) run(tbl[i], tags[i]);

      // 8-beat read with rready toggling 1,0,0,1,...
      run(c_aw(26'h100, 8'd7, EX_AWV), "aw_burst8");
      for (int i = 0; i < 8; i++)
         run(c_w(16'(16'h1000 + i), (i == 7)), "w_burst8");
      run(c_b(EX_B), "b_burst8");
      run(c_ar(26'h100, 8'd7, EX_IDLE), "ar_burst8");
      run(nop(EX_NONE), "r_fetch_burst8");
      beat = 0; rl_cnt = 0; done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         logic rr;
         rr = ((k % 3) == 0);
         run(c_r(rr, (beat == 7) ? EX_RL : EX_R, 16'(16'h1000 + beat)), "r_stall");
         if (rl_hs) rl_cnt++;
         if (rr) begin
            if (beat == 7) done = 1'b1;
            beat++;
         end
      end
      n_chk++;
      if (!done || rl_cnt != 1)
         $display("FAIL rlast_count: beats=%0d rlast_handshakes=%0d, required beats=8 rlast_handshakes=1", beat, rl_cnt);
      else
         n_pass++;
      run(nop(EX_IDLE), "idle_after_stall");

      // Simultaneous AW/AR: write wins, read taken after the B handshake
      v = c_aw(26'h200, 8'd0, EX_AWV); v.arv = 1'b1; v.ara = 26'h100; v.arl = 8'd7;
      run(v, "aw_ar_same_cycle");
      v = c_w(16'h7777, 1'b1); v.arv = 1'b1; v.ara = 26'h100; v.arl = 8'd7;
      run(v, "w_ar_pending");
      v = c_b(EX_B); v.arv = 1'b1; v.ara = 26'h100; v.arl = 8'd7;
      run(v, "b_ar_pending");
      run(c_ar(26'h100, 8'd7, EX_IDLE), "ar_after_b");
      run(nop(EX_NONE), "r_fetch_pending");
      run(c_r(1'b1, EX_R, 16'h1000), "r_pend1");
      run(c_r(1'b1, EX_R, 16'h1001), "r_pend2");
      v = c_r(1'b0, EX_R, 16'h1002); v.rstn = 1'b0;
      run(v, "pre_reset_read");
      v = nop(EX_IDLE); v.chk_rd = 1'b1; v.exd = 16'h0;
      run(v, "mid_read_reset");
      run(c_ar(26'h200, 8'd0, EX_IDLE), "ar_after_reset");
      run(nop(EX_NONE), "r_fetch_after_reset");
      run(c_r(1'b1, EX_RL, 16'h7777), "r_preserved_w");
      run(c_ar(26'h100, 8'd1, EX_IDLE), "ar_preserved");
      run(nop(EX_NONE), "r_fetch_preserved");
      run(c_r(1'b1, EX_R,  16'h1000), "r_preserved1");
      run(c_r(1'b1, EX_RL, 16'h1001), "r_preserved2");
      run(nop(EX_IDLE), "idle_final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
